peripheral_bus: RTL and testbench
=================================

// Module: peripheral_bus
// PURPOSE
//  Memory-mapped peripheral block downstream of the ALU: the ALU result (outZ) is the load/store
//  address, and data-memory accesses at or above BASE_ADDR are routed here instead of to data RAM.
//  Holds a reloadable timer with interrupt, LED and 7-segment output registers,
//  a synchronised switch input, and a free-running system tick counter.
//  Reads are combinational, to meet single-cycle load timing; writes commit on the clock edge.
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  base of the peripheral window (word-aligned map below)
//  LED_W      8              width of LED output register
//  SW_W       8              width of switch input
// PORTS
//  clk      in   1      system clock, all state on posedge
//  reset    in   1      asynchronous, active-low reset
//  addr     in   32     byte address from ALU result
//  wdata    in   32     store data (register rt)
//  rd       in   1      MemRead strobe for this cycle
//  wr       in   1      MemWrite strobe for this cycle
//  switch   in   SW_W   raw asynchronous board switches
//  rdata    out  32     read data, valid same cycle as rd
//  led      out  LED_W  LED register
//  digi     out  12     7-seg register: [11:8] digit anode enables, [7:0] segments
//  irqout   out  1      timer interrupt request, level
// BEHAVIOUR
//  Address map (offset from BASE_ADDR): 0x00 TH, 0x04 TL, 0x08 TCON[2:0], 0x0C LED,
//   0x10 SWITCH (RO), 0x14 DIGI, 0x18 SYSTICK (RO). Decode uses addr[31:5] for the window
//   and addr[4:2] for the register. addr[1:0] is ignored.
//  Reset (reset==0, async): TH=TL=0, TCON=0, led=0, digi=0, systick=0, sync flops=0, irqout=0.
//  Read: rdata = selected register zero-extended when rd=1 and the address hits a mapped offset.
//   rdata=0 when rd=0, the address is outside the window, or the offset is unmapped.
//   Reads have no side effects.
//  Write: on posedge with wr=1 and a hit, load wdata into the writable register.
//   Writes to RO or unmapped offsets are ignored. rd and wr high together: the write proceeds,
//   and rdata shows the pre-write value.
//  TCON: bit0 ENABLE, bit1 IRQ_EN, bit2 IRQ_STAT (sticky). Writing TCON loads all 3 bits.
//   This is how software clears IRQ_STAT.
//  Timer, each posedge with ENABLE=1:
//   - TL != 32'hFFFF_FFFF: TL <= TL+1.
//   - TL == 32'hFFFF_FFFF: TL <= TH (reload). If IRQ_EN=1, IRQ_STAT <= 1.
//  Timer with ENABLE=0: TL holds.
//  irqout = TCON[2], registered; it rises the cycle after the overflow edge.
//  Simultaneous CPU write and timer update:
//   - CPU write to TL wins over increment/reload.
//   - CPU write to TCON wins over the IRQ_STAT set.
//   - CPU write to TH in the overflow cycle: the reload uses the OLD TH.
//  SYSTICK: 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF -> 0, not writable.
//  SWITCH: 2-flop synchroniser. A read returns the value the switch input had 2 edges earlier.
//  led/digi are driven directly from their registers and change the cycle after the write edge.
// TESTING
//  1 Reset: assert reset low mid-count with TL=5, ENABLE=1 -> all outputs and regs 0
//    immediately, without waiting for clk.
//  2 Timer reload: TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3'b011 -> TL sequence
//    FFFF_FFFF, FFFF_FFFD, FFFF_FFFE. irqout=1 from the cycle after the reload edge and
//    stays 1 until TCON is written with bit2=0.
//  3 IRQ_EN=0: the same sequence with TCON=3'b001 -> TL reloads, irqout stays 0.
//  4 Collision: write TL=0x10 on the overflow edge -> TL=0x10, no reload.
//    Write TCON=3'b011 on the overflow edge -> IRQ_STAT=0.
//  5 Decode: write 0xA5 to 0x4000_000C -> led=0xA5. Write to 0x4000_0010 -> no change.
//    Read 0x4000_001C and 0x3FFF_FFFC -> rdata=0. Read 0x4000_0010 returns the switch value
//    2 cycles old.
//  6 SYSTICK: read at cycle N and at N+10 -> difference of exactly 10.

Source files
------------

// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED, 7-seg, switch and systick registers
// behind a word-aligned window at BASE_ADDR; combinational reads, clocked writes.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             rd,
    input  logic             wr,
    input  logic [SW_W-1:0]  switch,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] led,
    output logic [11:0]      digi,
    output logic             irqout
);
    logic [31:0]      th_q, th_d, tl_q, tl_d, systick_q;
    logic [2:0]       tcon_q, tcon_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [11:0]      digi_q, digi_d;
    logic [SW_W-1:0]  sw1_q, sw2_q;
    logic             hit, tl_max, we_th, we_tl, we_tcon, we_led, we_digi;
    logic [2:0]       sel;
    logic             unused_addr;

    assign unused_addr = ^addr[1:0];
    assign hit     = addr[31:5] == BASE_ADDR[31:5];
    assign sel     = addr[4:2];
    assign we_th   = wr && hit && sel == 3'd0;
    assign we_tl   = wr && hit && sel == 3'd1;
    assign we_tcon = wr && hit && sel == 3'd2;
    assign we_led  = wr && hit && sel == 3'd3;
    assign we_digi = wr && hit && sel == 3'd5;
    assign tl_max  = tl_q == 32'hFFFF_FFFF;

    // CPU writes take priority over timer updates; reload always sees the current TH.
    always_comb begin
        th_d   = we_th ? wdata : th_q;
        tl_d   = we_tl ? wdata : !tcon_q[0] ? tl_q : tl_max ? th_q : tl_q + 32'd1;
        tcon_d = we_tcon ? wdata[2:0]
               : {tcon_q[2] | (tcon_q[0] & tcon_q[1] & tl_max), tcon_q[1:0]};
        led_d  = we_led ? wdata[LED_W-1:0] : led_q;
        digi_d = we_digi ? wdata[11:0] : digi_q;
    end

    always_comb begin
        rdata = 32'd0;
        if (rd && hit)
            case (sel)
                3'd0:    rdata = th_q;
                3'd1:    rdata = tl_q;
                3'd2:    rdata = {29'd0, tcon_q};
                3'd3:    rdata = 32'(led_q);
                3'd4:    rdata = 32'(sw2_q);
                3'd5:    rdata = {20'd0, digi_q};
                3'd6:    rdata = systick_q;
                default: rdata = 32'd0;
            endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            sw1_q     <= '0;
            sw2_q     <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            sw1_q     <= switch;
            sw2_q     <= sw1_q;
            systick_q <= systick_q + 32'd1;
        end
    end

    assign led    = led_q;
    assign digi   = digi_q;
    assign irqout = tcon_q[2];
endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: directed vector table for decode plus hand-written timer,
// collision, synchroniser, systick and async-reset sequences.
module tb_peripheral_bus;
    localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008,
                            A_LED = 32'h4000_000C, A_SW = 32'h4000_0010, A_DIGI = 32'h4000_0014,
                            A_TICK = 32'h4000_0018;

    logic        clk = 1'b0, reset = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata, a, b;
    logic [7:0]  switch = 8'h3C, led;
    logic [11:0] digi;
    logic        irqout;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic        r;
        logic [31:0] er;
        logic [7:0]  el;
        logic [11:0] ed;
    } vec_t;
    vec_t v[12];

    peripheral_bus dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rd(rd), .wr(wr),
        .switch(switch), .rdata(rdata), .led(led), .digi(digi), .irqout(irqout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic wreg(input logic [31:0] ad, input logic [31:0] d);
        addr = ad; wdata = d; wr = 1'b1; rd = 1'b0;
        tick();
        wr = 1'b0;
    endtask

    task automatic rreg(input logic [31:0] ad, output logic [31:0] d);
        addr = ad; rd = 1'b1; wr = 1'b0;
        #1;
        d = rdata;
        rd = 1'b0;
    endtask

    initial begin
        v[0]  = '{A_LED,             32'h0000_00A5, 1'b1, 1'b0, 32'h0,          8'hA5, 12'h000};
        v[1]  = '{A_LED,             32'h0,         1'b0, 1'b1, 32'h0000_00A5,  8'hA5, 12'h000};
        v[2]  = '{A_SW,              32'h0000_0077, 1'b1, 1'b1, 32'h0000_003C,  8'hA5, 12'h000};
        v[3]  = '{A_DIGI,            32'hFFFF_F123, 1'b1, 1'b1, 32'h0,          8'hA5, 12'h123};
        v[4]  = '{A_DIGI,            32'h0,         1'b0, 1'b1, 32'h0000_0123,  8'hA5, 12'h123};
        v[5]  = '{32'h4000_001C,     32'h0,         1'b0, 1'b1, 32'h0,          8'hA5, 12'h123};
        v[6]  = '{32'h3FFF_FFFC,     32'h0,         1'b0, 1'b1, 32'h0,          8'hA5, 12'h123};
        v[7]  = '{32'h2000_000C,     32'h0000_0011, 1'b1, 1'b1, 32'h0,          8'hA5, 12'h123};
        v[8]  = '{A_LED,             32'h0,         1'b0, 1'b0, 32'h0,          8'hA5, 12'h123};
        v[9]  = '{32'h4000_000F,     32'h0,         1'b0, 1'b1, 32'h0000_00A5,  8'hA5, 12'h123};
        v[10] = '{A_TH,              32'h1234_5678, 1'b1, 1'b1, 32'h0,          8'hA5, 12'h123};
        v[11] = '{A_TCON,            32'hFFFF_FFF8, 1'b1, 1'b1, 32'h0,          8'hA5, 12'h123};

        // power-on reset
        #3;
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_digi", 32'(digi), 32'h0);
        chk("reset_irq", 32'(irqout), 32'h0);
        rreg(A_TICK, a);
        chk("reset_systick", a, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick();

        // decode table: rdata checked before the edge, led/digi after it
        for (int i = 0; i < 12; i++) begin
            addr = v[i].a; wdata = v[i].d; wr = v[i].w; rd = v[i].r;
            #1;
            chk($sformatf("vec%0d_rdata", i), rdata, v[i].er);
            tick();
            wr = 1'b0; rd = 1'b0;
            #1;
            chk($sformatf("vec%0d_led", i), 32'(led), 32'(v[i].el));
            chk($sformatf("vec%0d_digi", i), 32'(digi), 32'(v[i].ed));
        end
        rreg(A_TH, a);
        chk("th_readback", a, 32'h1234_5678);

        // switch synchroniser latency
        switch = 8'h5A;
        rreg(A_SW, a);
        chk("sw_0", a, 32'h3C);
        tick();
        rreg(A_SW, a);
        chk("sw_1", a, 32'h3C);
        tick();
        rreg(A_SW, a);
        chk("sw_2", a, 32'h5A);

        // systick
        rreg(A_TICK, a);
        repeat (10) tick();
        rreg(A_TICK, b);
        chk("systick_diff", b - a, 32'd10);

        // timer reload with interrupt
        wreg(A_TH, 32'hFFFF_FFFD);
        wreg(A_TL, 32'hFFFF_FFFE);
        wreg(A_TCON, 32'h3);
        tick(); rreg(A_TL, a);
        chk("t2_tl0", a, 32'hFFFF_FFFF);
        chk("t2_irq0", 32'(irqout), 32'h0);
        tick(); rreg(A_TL, a);
        chk("t2_tl1", a, 32'hFFFF_FFFD);
        chk("t2_irq1", 32'(irqout), 32'h1);
        tick(); rreg(A_TL, a);
        chk("t2_tl2", a, 32'hFFFF_FFFE);
        chk("t2_irq2", 32'(irqout), 32'h1);
        rreg(A_TCON, a);
        chk("t2_tcon", a, 32'h7);
        wreg(A_TCON, 32'h1);
        chk("t2_irq_clr", 32'(irqout), 32'h0);
        wreg(A_TCON, 32'h0);

        // reload without interrupt
        wreg(A_TL, 32'hFFFF_FFFE);
        wreg(A_TCON, 32'h1);
        tick(); rreg(A_TL, a);
        chk("t3_tl0", a, 32'hFFFF_FFFF);
        tick(); rreg(A_TL, a);
        chk("t3_tl1", a, 32'hFFFF_FFFD);
        chk("t3_irq1", 32'(irqout), 32'h0);
        tick(); rreg(A_TL, a);
        chk("t3_tl2", a, 32'hFFFF_FFFE);
        chk("t3_irq2", 32'(irqout), 32'h0);
        wreg(A_TCON, 32'h0);

        // collisions on the overflow edge
        wreg(A_TH, 32'h0000_AAAA);
        wreg(A_TL, 32'hFFFF_FFFE);
        wreg(A_TCON, 32'h3);
        tick();
        wreg(A_TL, 32'h0000_0010);
        rreg(A_TL, a);
        chk("t4_tl_write_wins", a, 32'h10);
        wreg(A_TL, 32'hFFFF_FFFF);
        wreg(A_TCON, 32'h3);
        rreg(A_TCON, a);
        chk("t4_tcon_write_wins", a, 32'h3);
        chk("t4_irq", 32'(irqout), 32'h0);
        rreg(A_TL, a);
        chk("t4_tl_reload", a, 32'h0000_AAAA);
        wreg(A_TH, 32'h0000_BBBB);
        wreg(A_TL, 32'hFFFF_FFFF);
        wreg(A_TH, 32'h0000_CCCC);
        rreg(A_TL, a);
        chk("t4_old_th_reload", a, 32'h0000_BBBB);
        rreg(A_TH, a);
        chk("t4_th_new", a, 32'h0000_CCCC);
        wreg(A_TCON, 32'h0);

        // async reset mid-count
        wreg(A_TL, 32'h5);
        wreg(A_TCON, 32'h1);
        tick(); tick();
        rreg(A_TL, a);
        chk("t1_tl_counting", a, 32'h7);
        #1;
        reset = 1'b0;
        #1;
        chk("t1_led", 32'(led), 32'h0);
        chk("t1_digi", 32'(digi), 32'h0);
        chk("t1_irq", 32'(irqout), 32'h0);
        rreg(A_TL, a);
        chk("t1_tl", a, 32'h0);
        rreg(A_TH, a);
        chk("t1_th", a, 32'h0);
        rreg(A_TCON, a);
        chk("t1_tcon", a, 32'h0);
        rreg(A_TICK, a);
        chk("t1_systick", a, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
